// File: rtl/shift_tx_controller_pkg.sv
// Shared constants and state encoding for the shift-register UART transmitter.
package shift_tx_controller_pkg;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHL  = 2'b01;
    localparam logic [1:0] SR_SHR  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

endpackage

// File: rtl/shift_tx_controller_bit_timer.sv
// Per-bit cycle counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module shift_tx_controller_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    assign o_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_tx_controller.sv
// Sequences an external 8-bit shift register to serialise bytes as UART frames, LSB first.
// state | meaning: IDLE wait for byte, LOAD shift register loads, START/DATA/PARITY/STOP one serial bit each
module shift_tx_controller
    import shift_tx_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int CNT_W        = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [1:0] o_sr_mode,
    output logic [7:0] o_sr_data_p,
    output logic       o_sr_data_s,
    input  logic [7:0] i_sr_q,
    output logic       o_tx_line,
    output logic       o_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  r_state, w_state_nxt;
    logic       r_tx_line, w_tx_line_nxt;
    logic       r_tx_ready, w_tx_ready_nxt;
    logic       r_busy, w_busy_nxt;
    logic [1:0] r_sr_mode, w_sr_mode_nxt;
    logic [7:0] r_sr_data_p, w_sr_data_p_nxt;
    logic       r_parity, w_parity_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       w_last;
    logic       w_accept;
    logic       w_timer_clear;
    logic       w_unused_sr_q;

    assign w_accept      = i_tx_valid && r_tx_ready;
    assign w_timer_clear = (r_state == IDLE) || (r_state == LOAD);
    assign w_unused_sr_q = ^i_sr_q[7:1];

    shift_tx_controller_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_timer_clear),
        .i_enable (!w_timer_clear),
        .o_last   (w_last)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_tx_line   <= 1'b1;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_sr_mode   <= SR_HOLD;
            r_sr_data_p <= 8'h00;
            r_parity    <= 1'b0;
            r_bit_cnt   <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_line   <= w_tx_line_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_sr_mode   <= w_sr_mode_nxt;
            r_sr_data_p <= w_sr_data_p_nxt;
            r_parity    <= w_parity_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = START;
            START:   if (w_last) w_state_nxt = DATA;
            DATA: begin
                if (w_last && (r_bit_cnt == LAST_BIT))
                    w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY:  if (w_last) w_state_nxt = STOP;
            STOP:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Each data bit begins with a one-cycle shift-right so sr_q[0] presents the next bit in time.
    always_comb begin
        w_tx_line_nxt   = r_tx_line;
        w_tx_ready_nxt  = r_tx_ready;
        w_busy_nxt      = r_busy;
        w_sr_mode_nxt   = SR_HOLD;
        w_sr_data_p_nxt = r_sr_data_p;
        w_parity_nxt    = r_parity;
        w_bit_cnt_nxt   = r_bit_cnt;
        unique case (r_state)
            IDLE: begin
                w_tx_line_nxt = 1'b1;
                if (w_accept) begin
                    w_sr_data_p_nxt = i_tx_data;
                    w_sr_mode_nxt   = SR_LOAD;
                    w_tx_ready_nxt  = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_parity_nxt    = ^i_tx_data;
                    w_bit_cnt_nxt   = 3'd0;
                end
            end
            LOAD: w_tx_line_nxt = 1'b0;
            START: begin
                if (w_last) begin
                    w_tx_line_nxt = i_sr_q[0];
                    w_sr_mode_nxt = SR_SHR;
                end
            end
            DATA: begin
                if (w_last) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_line_nxt = (PARITY_EN != 0) ? r_parity : 1'b1;
                    end else begin
                        w_tx_line_nxt = i_sr_q[0];
                        w_sr_mode_nxt = SR_SHR;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: if (w_last) w_tx_line_nxt = 1'b1;
            STOP: begin
                if (w_last) begin
                    w_tx_line_nxt  = 1'b1;
                    w_tx_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                end
            end
            default: begin
                w_tx_line_nxt  = 1'b1;
                w_tx_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    assign o_tx_line   = r_tx_line;
    assign o_tx_ready  = r_tx_ready;
    assign o_busy      = r_busy;
    assign o_sr_mode   = r_sr_mode;
    assign o_sr_data_p = r_sr_data_p;
    assign o_sr_data_s = 1'b1;

endmodule

// File: tb/tb_shift_tx_controller.sv
// Directed bench: three controller instances (4 clk/bit, 4 clk/bit + parity, 2 clk/bit) each driving a shift register model.
module tb_shift_tx_controller;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [7:0] tx_data [3];
    logic       tx_valid [3];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    logic       ready0, line0, busy0, ds0;
    logic [1:0] mode0;
    logic [7:0] p0, q0;
    logic       ready1, line1, busy1, ds1;
    logic [1:0] mode1;
    logic [7:0] p1, q1;
    logic       ready2, line2, busy2, ds2;
    logic [1:0] mode2;
    logic [7:0] p2, q2;

    shift_tx_controller #(.CLKS_PER_BIT(4), .PARITY_EN(0), .CNT_W(16)) u_dut0 (
        .i_clock(clk), .i_reset(rst_b), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(ready0), .o_sr_mode(mode0), .o_sr_data_p(p0), .o_sr_data_s(ds0),
        .i_sr_q(q0), .o_tx_line(line0), .o_busy(busy0));
    shift_tx_controller #(.CLKS_PER_BIT(4), .PARITY_EN(1), .CNT_W(16)) u_dut1 (
        .i_clock(clk), .i_reset(rst_b), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(ready1), .o_sr_mode(mode1), .o_sr_data_p(p1), .o_sr_data_s(ds1),
        .i_sr_q(q1), .o_tx_line(line1), .o_busy(busy1));
    shift_tx_controller #(.CLKS_PER_BIT(2), .PARITY_EN(0), .CNT_W(16)) u_dut2 (
        .i_clock(clk), .i_reset(rst_b), .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]),
        .o_tx_ready(ready2), .o_sr_mode(mode2), .o_sr_data_p(p2), .o_sr_data_s(ds2),
        .i_sr_q(q2), .o_tx_line(line2), .o_busy(busy2));

    // shift register models: hold / shift left / shift right / load, reset to 8'hFF
    always @(posedge clk) begin
        if (!rst_b) q0 <= 8'hFF;
        else case (mode0)
            2'b01: q0 <= {q0[6:0], ds0};
            2'b10: q0 <= {ds0, q0[7:1]};
            2'b11: q0 <= p0;
            default: q0 <= q0;
        endcase
    end
    always @(posedge clk) begin
        if (!rst_b) q1 <= 8'hFF;
        else case (mode1)
            2'b01: q1 <= {q1[6:0], ds1};
            2'b10: q1 <= {ds1, q1[7:1]};
            2'b11: q1 <= p1;
            default: q1 <= q1;
        endcase
    end
    always @(posedge clk) begin
        if (!rst_b) q2 <= 8'hFF;
        else case (mode2)
            2'b01: q2 <= {q2[6:0], ds2};
            2'b10: q2 <= {ds2, q2[7:1]};
            2'b11: q2 <= p2;
            default: q2 <= q2;
        endcase
    end

    // {line, ready, busy, mode[1:0], data_p[7:0]}
    function automatic logic [12:0] obs(input int i);
        case (i)
            0:       return {line0, ready0, busy0, mode0, p0};
            1:       return {line1, ready1, busy1, mode1, p1};
            default: return {line2, ready2, busy2, mode2, p2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d);
        logic [12:0] o;
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        o = obs(i);
        for (int k = 0; k < 200 && !o[11]; k++) begin
            @(negedge clk);
            o = obs(i);
        end
        chk("ready_wait", {31'd0, o[11]}, 32'd1);
        @(posedge clk);
    endtask

    // Called right after the handshake edge; checks LOAD, every bit cycle and the first IDLE cycle.
    task automatic check_frame(input int i, input logic [7:0] d, input logic [10:0] exp,
                               input int nbits, input int cpb,
                               input bit keep_valid, input logic [7:0] next_d);
        logic [12:0] o;
        int n_shr;
        int n_shl;
        n_shr = 0;
        n_shl = 0;
        @(negedge clk);
        o = obs(i);
        chk("load_mode", {30'd0, o[9:8]}, 32'd3);
        chk("load_data", {24'd0, o[7:0]}, {24'd0, d});
        chk("load_ready", {31'd0, o[11]}, 32'd0);
        chk("load_busy", {31'd0, o[10]}, 32'd1);
        if (keep_valid) tx_data[i] = next_d;
        else            tx_valid[i] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                o = obs(i);
                chk($sformatf("line_b%0d_c%0d", b, c), {31'd0, o[12]}, {31'd0, exp[b]});
                if (c == 0) chk($sformatf("ready_low_b%0d", b), {31'd0, o[11]}, 32'd0);
                if (o[9:8] == 2'b10) n_shr++;
                if (o[9:8] == 2'b01) n_shl++;
            end
        end
        chk("shr_pulses", n_shr, 32'd8);
        chk("shl_seen", n_shl, 32'd0);
        @(negedge clk);
        o = obs(i);
        chk("idle_ready", {31'd0, o[11]}, 32'd1);
        chk("idle_busy", {31'd0, o[10]}, 32'd0);
        chk("idle_line", {31'd0, o[12]}, 32'd1);
        chk("idle_data_kept", {24'd0, o[7:0]}, {24'd0, d});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] o;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b1;
            tx_data[i]  = 8'h99;
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = obs(i);
                chk("rst_line", {31'd0, o[12]}, 32'd1);
                chk("rst_ready", {31'd0, o[11]}, 32'd1);
                chk("rst_busy", {31'd0, o[10]}, 32'd0);
                chk("rst_mode", {30'd0, o[9:8]}, 32'd0);
            end
        end
        chk("rst_data_p", {24'd0, p0}, 32'd0);
        chk("serial_fill", {31'd0, ds0}, 32'd1);
        for (int i = 0; i < 3; i++) tx_valid[i] = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);

        send(0, 8'hA5);
        check_frame(0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0, 8'h00);

        send(1, 8'hA5);
        check_frame(1, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0, 8'h00);
        send(1, 8'h07);
        check_frame(1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, 1'b0, 8'h00);

        send(0, 8'hA5);
        check_frame(0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b1, 8'h3C);
        check_frame(0, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, 1'b0, 8'h00);

        send(0, 8'hA5);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        o = obs(0);
        chk("pre_abort_busy", {31'd0, o[10]}, 32'd1);
        rst_b = 1'b0;
        @(negedge clk);
        o = obs(0);
        chk("abort_line", {31'd0, o[12]}, 32'd1);
        chk("abort_mode", {30'd0, o[9:8]}, 32'd0);
        chk("abort_busy", {31'd0, o[10]}, 32'd0);
        chk("abort_ready", {31'd0, o[11]}, 32'd1);
        rst_b = 1'b1;
        @(negedge clk);
        send(0, 8'h5A);
        check_frame(0, 8'h5A, {1'b0, 1'b1, 8'h5A, 1'b0}, 10, 4, 1'b0, 8'h00);

        send(2, 8'h00);
        check_frame(2, 8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, 10, 2, 1'b1, 8'hFF);
        check_frame(2, 8'hFF, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 2, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
